assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache_pkg.sv | 21 ++
 rtl/cache_way.sv | 56 +++++
 rtl/assoc_cache.sv | 170 +++++++++++++++++
 tb/tb_assoc_cache.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared definitions for the 2-way set-associative cache: FSM state encodings
// and the victim-selection helper.
package assoc_cache_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOOKUP    = 4'd1,
    ST_WRITEBACK = 4'd2,
    ST_FILL      = 4'd3,
    ST_DONE      = 4'd4
  } state_t;

  // Prefer an empty way; only when both ways are occupied fall back to LRU.
  function automatic logic pick_victim(input logic valid0, input logic valid1,
                                       input logic lru);
    if (!valid0) return 1'b0;
    else if (!valid1) return 1'b1;
    else return lru;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag/data arrays with registered read (block-RAM style)
// plus per-set valid/dirty flags that are cleared by reset.
module cache_way #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [INDEX_BITS-1:0] set_index,
  input  logic                  wr_en,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  wr_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  valid,
  output logic                  dirty
);

  localparam int NUM_SETS = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
  logic [DATA_BITS-1:0] data_mem [NUM_SETS];
  logic [NUM_SETS-1:0]  valid_reg;
  logic [NUM_SETS-1:0]  dirty_reg;

  // Reads happen only when a request is accepted, so the registered outputs
  // keep describing the looked-up set (and any victim) for the whole access.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[set_index]  <= wr_tag;
      data_mem[set_index] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_index];
      rd_data <= data_mem[rd_index];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      valid_reg[set_index] <= 1'b1;
      dirty_reg[set_index] <= wr_dirty;
    end
  end

  assign valid = valid_reg[set_index];
  assign dirty = dirty_reg[set_index];

endmodule

// File: rtl/assoc_cache.sv
// 2-way set-associative write-back/write-allocate cache, one word per line.
// Define ASSOC_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int INDEX_BITS = 3,
  parameter int DATA_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic [DATA_BITS-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [3:0]           state
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int NUM_SETS = 1 << INDEX_BITS;

  state_t               state_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [DATA_BITS-1:0] wdata_reg;
  logic [DATA_BITS-1:0] line_data_reg;
  logic                 op_wr_reg;
  logic                 victim_reg;
  logic [NUM_SETS-1:0]  lru_reg;

  logic [INDEX_BITS-1:0] set_index;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [TAG_BITS-1:0]   way_tag  [2];
  logic [DATA_BITS-1:0]  way_data [2];
  logic [1:0]            way_valid, way_dirty, hit_way, way_wr;
  logic                  accept, hit, hit_sel, victim_next;
  logic [DATA_BITS-1:0]  fill_data;

  assign set_index   = addr_reg[INDEX_BITS-1:0];
  assign addr_tag    = addr_reg[ADDR_BITS-1:INDEX_BITS];
  assign accept      = (state_reg == ST_IDLE) && (cpu_rd || cpu_wr);
  assign hit         = |hit_way;
  assign hit_sel     = hit_way[1];
  assign victim_next = pick_victim(way_valid[0], way_valid[1], lru_reg[set_index]);
  // A write miss allocates with the CPU word directly; the fetched word is dropped.
  assign fill_data   = op_wr_reg ? wdata_reg : mem_rdata;
  assign state       = state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      cache_way #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (DATA_BITS)
      ) u_way (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (accept),
        .rd_index (cpu_addr[INDEX_BITS-1:0]),
        .set_index(set_index),
        .wr_en    (way_wr[gi]),
        .wr_tag   (addr_tag),
        .wr_data  (fill_data),
        .wr_dirty (op_wr_reg),
        .rd_tag   (way_tag[gi]),
        .rd_data  (way_data[gi]),
        .valid    (way_valid[gi]),
        .dirty    (way_dirty[gi])
      );
      assign hit_way[gi] = way_valid[gi] && (way_tag[gi] == addr_tag);
      assign way_wr[gi]  = ((state_reg == ST_LOOKUP) && hit_way[gi] && op_wr_reg) ||
                           ((state_reg == ST_FILL) && mem_ack && (victim_reg == 1'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      line_data_reg <= '0;
      op_wr_reg     <= 1'b0;
      victim_reg    <= 1'b0;
      lru_reg       <= '0;
      cpu_ready     <= 1'b0;
      cpu_rdata     <= '0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
`ifdef ASSOC_CACHE_STATS_EN
      hit_count     <= '0;
      miss_count    <= '0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg  <= cpu_addr;
            wdata_reg <= cpu_wdata;
            op_wr_reg <= cpu_wr;
            state_reg <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            line_data_reg      <= way_data[hit_sel];
            lru_reg[set_index] <= ~hit_sel;
            state_reg          <= ST_DONE;
`ifdef ASSOC_CACHE_STATS_EN
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
          end else begin
            victim_reg <= victim_next;
`ifdef ASSOC_CACHE_STATS_EN
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
            if (way_valid[victim_next] && way_dirty[victim_next]) begin
              mem_wr    <= 1'b1;
              mem_addr  <= {way_tag[victim_next], set_index};
              mem_wdata <= way_data[victim_next];
              state_reg <= ST_WRITEBACK;
            end else begin
              mem_rd    <= 1'b1;
              mem_addr  <= addr_reg;
              state_reg <= ST_FILL;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack) begin
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b1;
            mem_addr  <= addr_reg;
            state_reg <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            mem_rd             <= 1'b0;
            line_data_reg      <= mem_rdata;
            lru_reg[set_index] <= ~victim_reg;
            state_reg          <= ST_DONE;
          end
        end
        ST_DONE: begin
          cpu_ready <= 1'b1;
          if (!op_wr_reg) cpu_rdata <= line_data_reg;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: expected memory traffic and read data are
// queued when a request is issued and checked when the DUT produces them.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic [3:0]  state;
`ifdef ASSOC_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  logic ack_resp = 1'b0;
  logic ack_force = 1'b0;
  logic ack_en = 1'b1;
  assign mem_ack = ack_resp | ack_force;

  always #5 clk = ~clk;

  assoc_cache #(.ADDR_BITS(8), .INDEX_BITS(3), .DATA_BITS(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state(state)
`ifdef ASSOC_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } mem_ev_t;

  mem_ev_t     exp_mem_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mem_model [256];
  logic [31:0] last_rd = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_mem(input bit wr, input logic [7:0] a, input logic [31:0] d);
    mem_ev_t ev;
    ev.wr = wr;
    ev.addr = a;
    ev.data = d;
    exp_mem_q.push_back(ev);
  endtask

  // Main-memory responder: acknowledges each request one cycle after it appears.
  initial begin
    mem_ev_t ev;
    forever begin
      @(negedge clk);
      if (ack_resp) begin
        ack_resp = 1'b0;
      end else if ((mem_rd || mem_wr) && ack_en) begin
        check("mem_excl", 64'(mem_rd & mem_wr), 64'd0);
        if (exp_mem_q.size() == 0) begin
          check("mem_unexpected", {54'd0, mem_rd, mem_wr, mem_addr}, 64'd0);
        end else begin
          ev = exp_mem_q.pop_front();
          check("mem_wr", 64'(mem_wr), 64'(ev.wr));
          check("mem_addr", 64'(mem_addr), 64'(ev.addr));
          if (ev.wr) begin
            check("mem_wdata", 64'(mem_wdata), 64'(ev.data));
            mem_model[mem_addr] = mem_wdata;
          end
        end
        $display("[TB] mem %s addr=%02h data=%08h", mem_wr ? "wr" : "rd", mem_addr,
                 mem_wr ? mem_wdata : mem_model[mem_addr]);
        mem_rdata = mem_model[mem_addr];
        ack_resp = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_ready", 64'(cpu_ready), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
`ifdef ASSOC_CACHE_STATS_EN
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_misses", 64'(miss_count), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
  endtask

  task automatic do_op(input string name, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input bit want_hit);
    int lat = 0;
    logic [31:0] e;
    if (rd && !wr) exp_rd_q.push_back(exp_d);
    @(negedge clk);
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_rd = rd;
    cpu_wr = wr;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (cpu_ready) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      check({name, "_timeout"}, 64'(cpu_ready), 64'd1);
    end else begin
      if (want_hit) check({name, "_hit_latency"}, 64'(lat), 64'd2);
      if (rd && !wr) begin
        e = exp_rd_q.pop_front();
        check({name, "_rdata"}, 64'(cpu_rdata), 64'(e));
        last_rd = e;
      end else begin
        check({name, "_rdata_hold"}, 64'(cpu_rdata), 64'(last_rd));
      end
      @(posedge clk);
      #1;
      check({name, "_ready_pulse"}, 64'(cpu_ready), 64'd0);
    end
    $display("[TB] cpu %s %s addr=%02h wdata=%08h lat=%0d rdata=%08h", name,
             wr ? "wr" : "rd", a, wd, lat, cpu_rdata);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = {24'hC0FFEE, 8'(i)};
    mem_model[8'h15] = 32'hDEADBEEF;

    do_reset();
    // Cold miss, then a hit with no memory traffic.
    exp_mem(1'b0, 8'h15, '0);
    do_op("rd15_miss", 1'b1, 1'b0, 8'h15, '0, 32'hDEADBEEF, 1'b0);
    do_op("rd15_hit", 1'b1, 1'b0, 8'h15, '0, 32'hDEADBEEF, 1'b1);
`ifdef ASSOC_CACHE_STATS_EN
    check("stat_hits", 64'(hit_count), 64'd1);
    check("stat_misses", 64'(miss_count), 64'd1);
`endif

    // Write hit dirties way0; 0x35 fills way1; 0x55 evicts dirty 0x15.
    do_op("wr15_hit", 1'b0, 1'b1, 8'h15, 32'h12345678, '0, 1'b1);
    exp_mem(1'b0, 8'h35, '0);
    do_op("rd35_miss", 1'b1, 1'b0, 8'h35, '0, mem_model[8'h35], 1'b0);
    exp_mem(1'b1, 8'h15, 32'h12345678);
    exp_mem(1'b0, 8'h55, '0);
    do_op("rd55_evict", 1'b1, 1'b0, 8'h55, '0, mem_model[8'h55], 1'b0);
    exp_mem(1'b0, 8'h15, '0);
    do_op("rd15_refetch", 1'b1, 1'b0, 8'h15, '0, 32'h12345678, 1'b0);

    // LRU victim choice: touching 0x15 makes 0x35's way the clean victim.
    do_reset();
    exp_mem(1'b0, 8'h15, '0);
    do_op("lru_rd15", 1'b1, 1'b0, 8'h15, '0, 32'h12345678, 1'b0);
    exp_mem(1'b0, 8'h35, '0);
    do_op("lru_rd35", 1'b1, 1'b0, 8'h35, '0, mem_model[8'h35], 1'b0);
    do_op("lru_rd15_hit", 1'b1, 1'b0, 8'h15, '0, 32'h12345678, 1'b1);
    exp_mem(1'b0, 8'h55, '0);
    do_op("lru_rd55", 1'b1, 1'b0, 8'h55, '0, mem_model[8'h55], 1'b0);
    do_op("lru_rd15_kept", 1'b1, 1'b0, 8'h15, '0, 32'h12345678, 1'b1);

    // Reset while FILL waits, with mem_ack arriving together with reset.
    do_reset();
    ack_en = 1'b0;
    @(negedge clk);
    cpu_addr = 8'h15;
    cpu_rd = 1'b1;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rd) break;
    end
    check("abort_fill_rd", 64'(mem_rd), 64'd1);
    ack_force = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mem_rd", 64'(mem_rd), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    check("abort_ready", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    @(posedge clk);
    #1;
    check("abort_ack_ignored", 64'(state), 64'd0);
    @(negedge clk);
    ack_force = 1'b0;
    ack_en = 1'b1;
    exp_mem(1'b0, 8'h15, '0);
    do_op("abort_rd15_miss", 1'b1, 1'b0, 8'h15, '0, 32'h12345678, 1'b0);

    // Read and write together is a write; then evict it to see the dirty word.
    exp_mem(1'b0, 8'h22, '0);
    do_op("rdwr22", 1'b1, 1'b1, 8'h22, 32'hA5A5A5A5, '0, 1'b0);
    do_op("rd22_hit", 1'b1, 1'b0, 8'h22, '0, 32'hA5A5A5A5, 1'b1);
    exp_mem(1'b0, 8'h62, '0);
    do_op("rd62_miss", 1'b1, 1'b0, 8'h62, '0, mem_model[8'h62], 1'b0);
    exp_mem(1'b1, 8'h22, 32'hA5A5A5A5);
    exp_mem(1'b0, 8'hA2, '0);
    do_op("rdA2_evict", 1'b1, 1'b0, 8'hA2, '0, mem_model[8'hA2], 1'b0);

    repeat (3) @(posedge clk);
    check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
